// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - shared state encoding and sync-byte constant for the register dump transmitter
package reg_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    NEXT_BYTE
  } state_t;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - one 8N1 character (start, 8 data LSB-first, stop) with ready/load handshake
module uart_tx_byte
  import reg_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_tick,
  output logic       o_stop_near,
  output logic [2:0] o_bit,
  output logic       o_txd
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_NEAR = CW'(CLKS_PER_BIT - 2);

  state_t        r_phase;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_txd;

  assign o_busy      = (r_phase != IDLE);
  assign o_tick      = o_busy && (r_baud == BAUD_LAST);
  // Ready in the last stop-bit cycle too, so the next character follows with no idle gap.
  assign o_ready     = (r_phase == IDLE) || ((r_phase == STOP_BIT) && o_tick);
  assign o_stop_near = (r_phase == STOP_BIT) && (r_baud == BAUD_NEAR);
  assign o_bit       = r_bit;
  assign o_txd       = r_txd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else if (i_load && o_ready) begin
      r_phase <= START_BIT;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= i_data;
      r_txd   <= 1'b0;
    end else if (o_busy) begin
      if (!o_tick) begin
        r_baud <= r_baud + 1'b1;
      end else begin
        r_baud <= '0;
        case (r_phase)
          START_BIT: begin
            r_phase <= DATA_BITS;
            r_txd   <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
          end
          DATA_BITS: begin
            if (r_bit == 3'd7) begin
              r_phase <= STOP_BIT;
              r_txd   <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_txd   <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end
          default: r_phase <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/reg_dump_tx.sv
// rtl/reg_dump_tx.sv - dumps a 32-bit word MSB byte first as back-to-back 8N1 characters; REG_DUMP_TX_HEADER_EN adds a leading 0xA5 sync character
module reg_dump_tx
  import reg_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int NUM_BYTES    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        done,
  output logic        TxD
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_shift;
  logic [1:0]  r_idx;
  logic        r_done;
  logic        w_load;
  logic        w_advance;
  logic        w_hdr;
  logic [7:0]  w_byte;
  logic        w_ready;
  logic        w_busy;
  logic        w_tick;
  logic        w_stop_near;
  logic [2:0]  w_bit;

`ifdef REG_DUMP_TX_HEADER_EN
  logic r_hdr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hdr <= 1'b0;
    end else if ((r_state == IDLE) && (w_next == START_BIT)) begin
      r_hdr <= 1'b1;
    end else if (r_state == NEXT_BYTE) begin
      r_hdr <= 1'b0;
    end
  end

  assign w_hdr = r_hdr;
`else
  assign w_hdr = 1'b0;
`endif

  // NEXT_BYTE coincides with the final stop-bit cycle, so reloading there costs no line time.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_advance = 1'b0;
    w_byte    = r_shift[31:24];
    case (r_state)
      IDLE: begin
        if (start && !r_done) w_next = START_BIT;
      end
      START_BIT: begin
        if (w_ready) begin
          w_load = 1'b1;
          if (w_hdr) w_byte = HEADER_BYTE;
        end else if (w_tick) begin
          w_next = DATA_BITS;
        end
      end
      DATA_BITS: begin
        if (w_tick && (w_bit == 3'd7)) w_next = STOP_BIT;
      end
      STOP_BIT: begin
        if (w_stop_near) w_next = NEXT_BYTE;
      end
      NEXT_BYTE: begin
        if (w_hdr) begin
          w_load = 1'b1;
          w_next = START_BIT;
        end else if (r_idx != 2'(NUM_BYTES - 1)) begin
          w_load    = 1'b1;
          w_advance = 1'b1;
          w_byte    = r_shift[23:16];
          w_next    = START_BIT;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == NEXT_BYTE) && (w_next == IDLE);
      if ((r_state == IDLE) && (w_next == START_BIT)) begin
        r_shift <= data_in;
        r_idx   <= '0;
      end else if (w_advance) begin
        r_shift <= {r_shift[23:0], 8'h00};
        r_idx   <= r_idx + 2'd1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_data     (w_byte),
    .o_ready    (w_ready),
    .o_busy     (w_busy),
    .o_tick     (w_tick),
    .o_stop_near(w_stop_near),
    .o_bit      (w_bit),
    .o_txd      (TxD)
  );

  assign busy = w_busy;
  assign done = r_done;

endmodule
